sme_bank_ldst: RTL and testbench

SME_BANK_LDST -- requirements
Module: sme_bank_ldst

---
 rtl/sme_bank_ldst.sv | 156 +++++++++++++++
 tb/tb_sme_bank_ldst.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_bank_ldst.sv
// Share-bank load/store sequencer: moves shares 1..d-1 of one register between banks and memory.
// Optional macro SME_LDST_BUS_CLEAR_EN zeroes idle data wires and inserts a CLR cycle between shares.
module sme_bank_ldst #(
    parameter int XLEN = 32,
    parameter int SMAX = 4
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [XLEN-1:0] req_addr,
    input  logic [3:0]      req_reg,
    input  logic [3:0]      req_nshares,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_recv,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_error,
    output logic [3:0]      bank_sel,
    output logic            bank_wen,
    output logic [3:0]      bank_waddr,
    output logic [XLEN-1:0] bank_wdata,
    output logic            bank_read,
    input  logic [XLEN-1:0] bank_rdata,
    output logic            done_valid,
    output logic            done_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CLR,
        S_DONE
    } state_t;

    localparam logic [3:0] SMAX_W = 4'(SMAX);

    state_t          state;
    logic [3:0]      k;
    logic [3:0]      d_eff;
    logic [3:0]      reg_q;
    logic [XLEN-1:0] addr_q;
    logic            store_q;
    logic            err_q;
    logic            flushing;

    logic [3:0]      nshares_clamped;
    logic            more_shares;
    logic            resp_ok;
    logic            in_txn;

    assign nshares_clamped = (req_nshares > SMAX_W) ? SMAX_W : req_nshares;
    assign more_shares     = (k < (d_eff - 4'd1));
    // A response is only consumed into the bank if no flush is pending or arriving.
    assign resp_ok         = (state == S_WAIT) && mem_recv && !mem_error && !flushing && !flush;
    assign in_txn          = (state == S_REQ) || (state == S_WAIT);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state    <= S_IDLE;
            k        <= '0;
            d_eff    <= '0;
            reg_q    <= '0;
            addr_q   <= '0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
            flushing <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!flush && req_valid) begin
                        store_q  <= req_store;
                        addr_q   <= req_addr;
                        reg_q    <= req_reg;
                        d_eff    <= nshares_clamped;
                        k        <= 4'd1;
                        err_q    <= 1'b0;
                        flushing <= 1'b0;
                        state    <= (nshares_clamped <= 4'd1) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    // A grant wins over flush: the access is out and its response must be drained.
                    if (mem_gnt) begin
                        flushing <= flush;
                        state    <= S_WAIT;
                    end else if (flush) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mem_recv) begin
                        if (flushing || flush) begin
                            flushing <= 1'b0;
                            state    <= S_IDLE;
                        end else if (mem_error) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else if (more_shares) begin
                            k      <= k + 4'd1;
                            addr_q <= addr_q + XLEN'(4);
`ifdef SME_LDST_BUS_CLEAR_EN
                            state  <= S_CLR;
`else
                            state  <= S_REQ;
`endif
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (flush) begin
                        flushing <= 1'b1;
                    end
                end
                S_CLR: begin
                    state <= flush ? S_IDLE : S_REQ;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        mem_req    = (state == S_REQ);
        mem_wen    = (state == S_REQ) && store_q;
        bank_read  = (state == S_REQ) && store_q;
        bank_wen   = resp_ok && !store_q;
        done_valid = (state == S_DONE) && !flush;
        done_error = done_valid && err_q;
`ifdef SME_LDST_BUS_CLEAR_EN
        mem_addr   = mem_req ? addr_q : '0;
        mem_wdata  = mem_wen ? bank_rdata : '0;
        bank_sel   = (bank_wen || bank_read) ? k : '0;
        bank_waddr = bank_wen ? reg_q : '0;
        bank_wdata = bank_wen ? mem_rdata : '0;
`else
        mem_addr   = addr_q;
        mem_wdata  = (in_txn && store_q) ? bank_rdata : '0;
        bank_sel   = k;
        bank_waddr = reg_q;
        bank_wdata = (in_txn && !store_q) ? mem_rdata : '0;
`endif
    end

endmodule

// File: tb/tb_sme_bank_ldst.sv
// Directed bench for sme_bank_ldst; honours SME_LDST_BUS_CLEAR_EN when the build defines it.
module tb_sme_bank_ldst;

    logic        g_clk = 1'b0;
    logic        g_reset, flush, req_valid, req_ready, req_store;
    logic [31:0] req_addr;
    logic [3:0]  req_reg, req_nshares;
    logic        mem_req, mem_gnt, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_recv, mem_error;
    logic [31:0] mem_rdata;
    logic [3:0]  bank_sel, bank_waddr;
    logic        bank_wen, bank_read;
    logic [31:0] bank_wdata, bank_rdata;
    logic        done_valid, done_error;

    int n_assert = 0;
    int n_fail   = 0;
    int wen_cnt  = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int wen0, hs0, done0;
    logic [3:0] exp_reg;

    sme_bank_ldst #(.XLEN(32), .SMAX(4)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_reg(req_reg), .req_nshares(req_nshares),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_recv(mem_recv), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .bank_sel(bank_sel), .bank_wen(bank_wen), .bank_waddr(bank_waddr),
        .bank_wdata(bank_wdata), .bank_read(bank_read), .bank_rdata(bank_rdata),
        .done_valid(done_valid), .done_error(done_error)
    );

    always #5 g_clk = ~g_clk;

    always @(posedge g_clk) begin
        if (bank_wen) wen_cnt++;
        if (mem_req && mem_gnt) hs_cnt++;
        if (done_valid) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge g_clk);
    endtask

    task automatic issue(input logic st, input logic [31:0] a, input logic [3:0] r, input logic [3:0] n);
        req_valid = 1'b1; req_store = st; req_addr = a; req_reg = r; req_nshares = n;
        exp_reg = r;
        mid();
        chk("idle_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic share(input logic [31:0] a, input logic [3:0] sel, input logic st,
                         input logic [31:0] d, input logic er, input logic last);
        mem_gnt = 1'b1;
        bank_rdata = st ? d : 32'h0;
        mid();
        chk("req_mem_req", mem_req, 1);
        chk("req_mem_addr", mem_addr, a);
        chk("req_mem_wen", mem_wen, st);
        chk("req_bank_read", bank_read, st);
        chk("req_busy_ready", req_ready, 0);
        if (st) begin
            chk("req_mem_wdata", mem_wdata, d);
            chk("req_bank_sel", bank_sel, sel);
        end
`ifdef SME_LDST_BUS_CLEAR_EN
        if (!st) chk("req_load_bank_sel_clr", bank_sel, 0);
`endif
        step();
        mem_gnt = 1'b0; bank_rdata = 32'h0;
        mem_recv = 1'b1; mem_error = er; mem_rdata = st ? 32'hDEADBEEF : d;
        mid();
        chk("wait_mem_req", mem_req, 0);
        chk("wait_bank_read", bank_read, 0);
        chk("wait_bank_wen", bank_wen, !st && !er);
        if (!st && !er) begin
            chk("wait_bank_waddr", bank_waddr, exp_reg);
            chk("wait_bank_wdata", bank_wdata, d);
            chk("wait_bank_sel", bank_sel, sel);
        end
`ifdef SME_LDST_BUS_CLEAR_EN
        if (st || er) chk("wait_bank_wdata_clr", bank_wdata, 0);
        if (st) chk("wait_mem_wdata_clr", mem_wdata, 0);
`endif
        step();
        mem_recv = 1'b0; mem_error = 1'b0; mem_rdata = 32'h0;
`ifdef SME_LDST_BUS_CLEAR_EN
        if (!last && !er) begin
            mid();
            chk("clr_mem_req", mem_req, 0);
            chk("clr_mem_addr", mem_addr, 0);
            chk("clr_mem_wdata", mem_wdata, 0);
            chk("clr_bank_sel", bank_sel, 0);
            chk("clr_bank_wen", bank_wen, 0);
            step();
        end
`endif
    endtask

    task automatic finish_txn(input logic er);
        mid();
        chk("done_valid", done_valid, 1);
        chk("done_error", done_error, er);
        chk("done_mem_req", mem_req, 0);
        step();
        mid();
        chk("post_done_ready", req_ready, 1);
        chk("post_done_valid", done_valid, 0);
        step();
    endtask

    initial begin
        g_reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        req_addr = '0; req_reg = '0; req_nshares = '0;
        mem_gnt = 1'b0; mem_recv = 1'b0; mem_error = 1'b0; mem_rdata = '0; bank_rdata = '0;
        exp_reg = '0;
        step(); step();
        mid();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_bank_sel", bank_sel, 0);
        chk("rst_done_valid", done_valid, 0);
        step();
        g_reset = 1'b0;

        // stray response in IDLE must not touch the bank
        mem_recv = 1'b1; mem_rdata = 32'hCAFEF00D;
        mid();
        chk("idle_recv_bank_wen", bank_wen, 0);
        step();
        mem_recv = 1'b0; mem_rdata = '0;

        // load d=3
        wen0 = wen_cnt; done0 = done_cnt;
        issue(1'b0, 32'h1000, 4'd5, 4'd3);
        share(32'h1000, 4'd1, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);
        share(32'h1004, 4'd2, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1);
        finish_txn(1'b0);
        chk("load3_wen_count", wen_cnt - wen0, 2);
        chk("load3_done_count", done_cnt - done0, 1);

        // store d=4
        hs0 = hs_cnt; wen0 = wen_cnt;
        issue(1'b1, 32'h2000, 4'd3, 4'd4);
        share(32'h2000, 4'd1, 1'b1, 32'h11, 1'b0, 1'b0);
        share(32'h2004, 4'd2, 1'b1, 32'h22, 1'b0, 1'b0);
        share(32'h2008, 4'd3, 1'b1, 32'h33, 1'b0, 1'b1);
        finish_txn(1'b0);
        chk("store4_hs_count", hs_cnt - hs0, 3);
        chk("store4_wen_count", wen_cnt - wen0, 0);

        // load d=4, bus error on the second response
        hs0 = hs_cnt; wen0 = wen_cnt;
        issue(1'b0, 32'h3000, 4'd2, 4'd4);
        share(32'h3000, 4'd1, 1'b0, 32'h01234567, 1'b0, 1'b0);
        share(32'h3004, 4'd2, 1'b0, 32'h89ABCDEF, 1'b1, 1'b1);
        finish_txn(1'b1);
        chk("err_hs_count", hs_cnt - hs0, 2);
        chk("err_wen_count", wen_cnt - wen0, 1);

        // flush while waiting; response three cycles later is discarded
        wen0 = wen_cnt; done0 = done_cnt;
        issue(1'b0, 32'h4000, 4'd7, 4'd3);
        mem_gnt = 1'b1;
        mid();
        chk("fl_mem_req", mem_req, 1);
        step();
        mem_gnt = 1'b0; flush = 1'b1;
        mid();
        chk("fl_w0_ready", req_ready, 0);
        step();
        flush = 1'b0;
        mid();
        chk("fl_w1_ready", req_ready, 0);
        step();
        mid();
        chk("fl_w2_mem_req", mem_req, 0);
        step();
        mem_recv = 1'b1; mem_rdata = 32'h77777777;
        mid();
        chk("fl_w3_bank_wen", bank_wen, 0);
        chk("fl_w3_done", done_valid, 0);
        step();
        mem_recv = 1'b0; mem_rdata = '0;
        mid();
        chk("fl_after_ready", req_ready, 1);
        chk("fl_after_done", done_valid, 0);
        step();
        chk("fl_wen_count", wen_cnt - wen0, 0);
        chk("fl_done_count", done_cnt - done0, 0);

        // d=1: straight to DONE
        hs0 = hs_cnt;
        issue(1'b0, 32'h4800, 4'd1, 4'd1);
        finish_txn(1'b0);
        chk("d1_hs_count", hs_cnt - hs0, 0);

        // d=9 clamps to SMAX=4 -> three shares
        hs0 = hs_cnt; wen0 = wen_cnt;
        issue(1'b0, 32'h5000, 4'd9, 4'd9);
        share(32'h5000, 4'd1, 1'b0, 32'h10101010, 1'b0, 1'b0);
        share(32'h5004, 4'd2, 1'b0, 32'h20202020, 1'b0, 1'b0);
        share(32'h5008, 4'd3, 1'b0, 32'h30303030, 1'b0, 1'b1);
        finish_txn(1'b0);
        chk("d9_hs_count", hs_cnt - hs0, 3);
        chk("d9_wen_count", wen_cnt - wen0, 3);

        // address wraps modulo 2^32
        issue(1'b1, 32'hFFFFFFFC, 4'd4, 4'd3);
        share(32'hFFFFFFFC, 4'd1, 1'b1, 32'h44, 1'b0, 1'b0);
        share(32'h00000000, 4'd2, 1'b1, 32'h55, 1'b0, 1'b1);
        finish_txn(1'b0);

        // asynchronous reset in REQ with no grant
        done0 = done_cnt;
        issue(1'b1, 32'h6000, 4'd6, 4'd2);
        bank_rdata = 32'h66;
        mid();
        chk("rr_mem_req", mem_req, 1);
        #2 g_reset = 1'b1;
        #1;
        chk("rr_mem_req_zero", mem_req, 0);
        chk("rr_mem_wen_zero", mem_wen, 0);
        chk("rr_bank_read_zero", bank_read, 0);
        chk("rr_mem_addr_zero", mem_addr, 0);
        chk("rr_mem_wdata_zero", mem_wdata, 0);
        chk("rr_bank_sel_zero", bank_sel, 0);
        chk("rr_req_ready", req_ready, 1);
        step();
        g_reset = 1'b0; bank_rdata = '0;
        mid();
        chk("rr_after_ready", req_ready, 1);
        step();
        step();
        chk("rr_done_count", done_cnt - done0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
